pipe_fwd_chain: RTL and testbench

Parametrised in-order pipeline tracking chain with operand forwarding and load-use interlock. It sits between decode and the register file. It carries result metadata (valid, write-enable, load flag, destination register, data) through `STAGES` pipeline positions. It resolves source-operand forwarding for two decode read ports and generates the decode stall/bubble, generalising the fixed EX/MEM/WB forwarding and `wpcir` freeze to an arbitrary depth and load latency. It also drives the register-file write port from its oldest stage and counts stall cycles.

---
 rtl/pipe_fwd_chain.sv | 145 ++++++++++++++
 tb/tb_pipe_fwd_chain.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_fwd_chain.sv
// In-order result-tracking chain: operand forwarding, load-use interlock, register-file writeback.
// Latency: forwarding, stall and writeback outputs are combinational; an issue reaches stage k after k+1 edges.
// Backpressure: none downstream (the chain always shifts); stall holds decode while a load result is not ready.
module pipe_fwd_chain #(
    parameter int STAGES     = 3,
    parameter int DATA_W     = 32,
    parameter int RN_W       = 5,
    parameter int LOAD_STAGE = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic              in_wreg,
    input  logic              in_m2reg,
    input  logic [RN_W-1:0]   in_rn,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              flush,
    input  logic [RN_W-1:0]   qa_rn,
    input  logic [RN_W-1:0]   qb_rn,
    input  logic              q_use_a,
    input  logic              q_use_b,
    output logic [DATA_W-1:0] fwd_a,
    output logic [DATA_W-1:0] fwd_b,
    output logic              hit_a,
    output logic              hit_b,
    output logic              stall,
    output logic              wb_we,
    output logic [RN_W-1:0]   wb_rn,
    output logic [DATA_W-1:0] wb_data,
    output logic [15:0]       stall_cnt
);

    // One tracked result: stage 0 is the youngest entry, STAGES-1 the one retiring.
    typedef struct packed {
        logic              v;
        logic              wreg;
        logic              m2reg;
        logic [RN_W-1:0]   rn;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              stg_q [STAGES];
    ent_t              stg_d [STAGES];
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_d;
    logic              issue;

    // Both read ports are resolved by the same loop, indexed 0 = a, 1 = b.
    logic [RN_W-1:0]   q_rn  [2];
    logic              hit   [2];
    logic              haz   [2];
    logic [DATA_W-1:0] fwd   [2];

    assign q_rn[0] = qa_rn;
    assign q_rn[1] = qb_rn;

    // Forwarding search: scan oldest to youngest so the youngest matching writer overrides.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            hit[p] = 1'b0;
            haz[p] = 1'b0;
            fwd[p] = '0;
            if (q_rn[p] != '0) begin
                for (int k = STAGES - 1; k >= 0; k--) begin
                    if (stg_q[k].v && stg_q[k].wreg && (stg_q[k].rn == q_rn[p])) begin
                        if (stg_q[k].m2reg && (k < LOAD_STAGE)) begin
                            // load data not yet returned from memory
                            hit[p] = 1'b0;
                            haz[p] = 1'b1;
                            fwd[p] = '0;
                        end else if (stg_q[k].m2reg && (k == LOAD_STAGE)) begin
                            // load data arrives this cycle; bypass it straight from the memory port
                            hit[p] = 1'b1;
                            haz[p] = 1'b0;
                            fwd[p] = ld_data;
                        end else begin
                            hit[p] = 1'b1;
                            haz[p] = 1'b0;
                            fwd[p] = stg_q[k].data;
                        end
                    end
                end
            end
        end
    end

    assign hit_a = hit[0];
    assign hit_b = hit[1];
    assign fwd_a = fwd[0];
    assign fwd_b = fwd[1];

    // The interlock only matters for sources decode actually reads; flush does not mask it.
    assign stall = (q_use_a & haz[0]) | (q_use_b & haz[1]);
    assign issue = in_valid & ~stall & ~flush;

    // Next chain contents: new issue or bubble into stage 0, everything else shifts by one.
    always_comb begin
        stg_d[0] = '0;
        if (issue) begin
            stg_d[0].v     = 1'b1;
            stg_d[0].wreg  = in_wreg;
            stg_d[0].m2reg = in_m2reg;
            stg_d[0].rn    = in_rn;
            stg_d[0].data  = in_data;
        end
        for (int k = 1; k < STAGES; k++) begin
            stg_d[k] = stg_q[k-1];
            // a load leaving the memory stage picks up its read data
            if (((k - 1) == LOAD_STAGE) && stg_q[k-1].m2reg) begin
                stg_d[k].data = ld_data;
            end
        end
    end

    // Stall-cycle counter, saturating at all ones.
    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Chain and counter registers; reset discards every in-flight entry.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < STAGES; k++) begin
                stg_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                stg_q[k] <= stg_d[k];
            end
            cnt_q <= cnt_d;
        end
    end

    // Register-file write port driven from the oldest stage; r0 is never written.
    assign wb_we     = stg_q[STAGES-1].v & stg_q[STAGES-1].wreg & (stg_q[STAGES-1].rn != '0);
    assign wb_rn     = stg_q[STAGES-1].rn;
    assign wb_data   = stg_q[STAGES-1].data;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_fwd_chain.sv
// Bench for pipe_fwd_chain: default instance checked every cycle against an in-flight-instruction model,
// deeper instances exercised for multi-cycle load-use interlock and stall counter saturation.
module tb_pipe_fwd_chain;

    localparam int A_S  = 3;
    localparam int A_LS = 1;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    // default-parameter instance
    logic        a_in_valid, a_in_wreg, a_in_m2reg, a_flush, a_use_a, a_use_b;
    logic [4:0]  a_in_rn, a_qa, a_qb;
    logic [31:0] a_in_data, a_ld;
    logic [31:0] a_fwd_a, a_fwd_b, a_wb_data;
    logic        a_hit_a, a_hit_b, a_stall, a_wb_we;
    logic [4:0]  a_wb_rn;
    logic [15:0] a_stall_cnt;

    // shared stimulus for the deep instances
    logic        b_in_valid, b_in_wreg, b_in_m2reg, b_flush, b_use_a, b_use_b;
    logic [4:0]  b_in_rn, b_qa, b_qb;
    logic [31:0] b_in_data, b_ld;
    logic [31:0] b_fwd_a, b_fwd_b, b_wb_data, c_fwd_a, c_fwd_b, c_wb_data;
    logic        b_hit_a, b_hit_b, b_stall, b_wb_we, c_hit_a, c_hit_b, c_stall, c_wb_we;
    logic [4:0]  b_wb_rn, c_wb_rn;
    logic [15:0] b_stall_cnt, c_stall_cnt;

    pipe_fwd_chain dut_a (
        .clock(clock), .resetn(resetn), .in_valid(a_in_valid), .in_wreg(a_in_wreg),
        .in_m2reg(a_in_m2reg), .in_rn(a_in_rn), .in_data(a_in_data), .ld_data(a_ld),
        .flush(a_flush), .qa_rn(a_qa), .qb_rn(a_qb), .q_use_a(a_use_a), .q_use_b(a_use_b),
        .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .hit_a(a_hit_a), .hit_b(a_hit_b), .stall(a_stall),
        .wb_we(a_wb_we), .wb_rn(a_wb_rn), .wb_data(a_wb_data), .stall_cnt(a_stall_cnt)
    );

    pipe_fwd_chain #(.STAGES(5), .LOAD_STAGE(3)) dut_b (
        .clock(clock), .resetn(resetn), .in_valid(b_in_valid), .in_wreg(b_in_wreg),
        .in_m2reg(b_in_m2reg), .in_rn(b_in_rn), .in_data(b_in_data), .ld_data(b_ld),
        .flush(b_flush), .qa_rn(b_qa), .qb_rn(b_qb), .q_use_a(b_use_a), .q_use_b(b_use_b),
        .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .hit_a(b_hit_a), .hit_b(b_hit_b), .stall(b_stall),
        .wb_we(b_wb_we), .wb_rn(b_wb_rn), .wb_data(b_wb_data), .stall_cnt(b_stall_cnt)
    );

    pipe_fwd_chain #(.STAGES(8), .LOAD_STAGE(6)) dut_c (
        .clock(clock), .resetn(resetn), .in_valid(b_in_valid), .in_wreg(b_in_wreg),
        .in_m2reg(b_in_m2reg), .in_rn(b_in_rn), .in_data(b_in_data), .ld_data(b_ld),
        .flush(b_flush), .qa_rn(b_qa), .qb_rn(b_qb), .q_use_a(b_use_a), .q_use_b(b_use_b),
        .fwd_a(c_fwd_a), .fwd_b(c_fwd_b), .hit_a(c_hit_a), .hit_b(c_hit_b), .stall(c_stall),
        .wb_we(c_wb_we), .wb_rn(c_wb_rn), .wb_data(c_wb_data), .stall_cnt(c_stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: list of issued instructions, each tagged with its age in cycles.
    typedef struct {
        int          age;
        bit          wreg;
        bit          m2reg;
        logic [4:0]  rn;
        logic [31:0] data;
    } rec_t;

    rec_t        mq[$];
    logic [15:0] m_cnt;
    bit          m_stall;

    function automatic void m_lookup(input logic [4:0] rn, output bit hit, output bit haz,
                                     output logic [31:0] fwd);
        int best = -1;
        hit = 1'b0; haz = 1'b0; fwd = '0;
        if (rn == 5'd0) return;
        foreach (mq[i]) begin
            if (mq[i].wreg && mq[i].rn == rn && (best < 0 || mq[i].age < mq[best].age)) best = i;
        end
        if (best < 0) return;
        if (mq[best].m2reg && mq[best].age < A_LS) haz = 1'b1;
        else if (mq[best].m2reg && mq[best].age == A_LS) begin hit = 1'b1; fwd = a_ld; end
        else begin hit = 1'b1; fwd = mq[best].data; end
    endfunction

    task automatic a_eval();
        bit ha, za, hb, zb, we;
        logic [31:0] fa, fb, wd;
        logic [4:0] wr;
        m_lookup(a_qa, ha, za, fa);
        m_lookup(a_qb, hb, zb, fb);
        m_stall = (a_use_a && za) || (a_use_b && zb);
        we = 1'b0; wr = '0; wd = '0;
        foreach (mq[i]) begin
            if (mq[i].age == A_S - 1) begin
                wr = mq[i].rn; wd = mq[i].data; we = mq[i].wreg && (mq[i].rn != 5'd0);
            end
        end
        chk("hit_a", a_hit_a, ha);
        chk("fwd_a", a_fwd_a, fa);
        chk("hit_b", a_hit_b, hb);
        chk("fwd_b", a_fwd_b, fb);
        chk("stall", a_stall, m_stall);
        chk("wb_we", a_wb_we, we);
        chk("wb_rn", a_wb_rn, wr);
        chk("wb_data", a_wb_data, wd);
        chk("stall_cnt", a_stall_cnt, m_cnt);
    endtask

    task automatic a_set(input logic v, input logic w, input logic m, input logic [4:0] rn,
                         input logic [31:0] d, input logic fl, input logic [4:0] qa, input logic ua,
                         input logic [4:0] qb, input logic ub, input logic [31:0] ld);
        a_in_valid = v; a_in_wreg = w; a_in_m2reg = m; a_in_rn = rn; a_in_data = d;
        a_flush = fl; a_qa = qa; a_use_a = ua; a_qb = qb; a_use_b = ub; a_ld = ld;
        #1 a_eval();
    endtask

    // Advance one clock; the model ages every instruction and admits the new one if it issued.
    task automatic a_tick();
        rec_t nq[$];
        rec_t r;
        @(posedge clock);
        foreach (mq[i]) begin
            if (mq[i].m2reg && mq[i].age == A_LS) mq[i].data = a_ld;
            mq[i].age++;
        end
        foreach (mq[i]) if (mq[i].age < A_S) nq.push_back(mq[i]);
        mq = nq;
        if (a_in_valid && !m_stall && !a_flush) begin
            r.age = 0; r.wreg = a_in_wreg; r.m2reg = a_in_m2reg; r.rn = a_in_rn; r.data = a_in_data;
            mq.push_back(r);
        end
        if (m_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        @(negedge clock);
    endtask

    int c_seen = 0;

    task automatic b_set(input logic v, input logic w, input logic m, input logic [4:0] rn,
                         input logic [31:0] d, input logic [4:0] qa, input logic ua, input logic [31:0] ld);
        b_in_valid = v; b_in_wreg = w; b_in_m2reg = m; b_in_rn = rn; b_in_data = d;
        b_flush = 1'b0; b_qa = qa; b_use_a = ua; b_qb = 5'd0; b_use_b = 1'b0; b_ld = ld;
        #1;
    endtask

    task automatic b_tick();
        if (c_stall) c_seen++;
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    initial begin
        int nst;
        int guard;
        bit seen1k;
        resetn = 1'b0;
        m_cnt  = '0;
        b_set(0, 0, 0, 0, 0, 0, 0, 0);
        a_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 resetn = 1'b1;
        @(negedge clock);

        // ALU result forwarded from stage 0, then written back after three edges
        a_set(1, 1, 0, 5'd3, 32'h11, 0, 0, 0, 0, 0, 0); a_tick();
        a_set(0, 0, 0, 0, 0, 0, 5'd3, 1, 0, 0, 0);
        chk("t1_hit", a_hit_a, 1); chk("t1_fwd", a_fwd_a, 32'h11); chk("t1_stall", a_stall, 0);
        a_tick();
        a_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); a_tick();
        a_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_wb_we", a_wb_we, 1); chk("t1_wb_rn", a_wb_rn, 3); chk("t1_wb_data", a_wb_data, 32'h11);
        a_tick();

        // load-use: one stall, then forward from the memory port, then writeback of the loaded value
        a_set(1, 1, 1, 5'd4, 32'hDEAD, 0, 0, 0, 0, 0, 0); a_tick();
        a_set(1, 1, 0, 5'd7, 32'h77, 0, 5'd4, 1, 0, 0, 32'h1234);
        chk("t2_stall", a_stall, 1);
        a_tick();
        a_set(1, 1, 0, 5'd7, 32'h77, 0, 5'd4, 1, 0, 0, 32'hCAFE);
        chk("t2_stall_end", a_stall, 0); chk("t2_hit", a_hit_a, 1); chk("t2_fwd", a_fwd_a, 32'hCAFE);
        a_tick();
        a_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5555);
        chk("t2_wb_rn", a_wb_rn, 4); chk("t2_wb_data", a_wb_data, 32'hCAFE);
        a_tick();

        // two writers of r5: youngest wins; r0 never hits; unused source never stalls
        a_set(1, 1, 0, 5'd5, 32'h1, 0, 0, 0, 0, 0, 0); a_tick();
        a_set(1, 1, 0, 5'd5, 32'h2, 0, 0, 0, 0, 0, 0); a_tick();
        a_set(0, 0, 0, 0, 0, 0, 5'd5, 1, 5'd0, 1, 0);
        chk("t3_fwd", a_fwd_a, 32'h2); chk("t3_r0_hit", a_hit_b, 0); chk("t3_stall", a_stall, 0);
        a_tick();
        a_set(1, 1, 1, 5'd5, 0, 0, 0, 0, 0, 0, 0); a_tick();
        a_set(0, 0, 0, 0, 0, 0, 5'd5, 0, 5'd0, 1, 0);
        chk("t3_nouse_stall", a_stall, 0);
        a_tick();
        repeat (3) begin a_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); a_tick(); end

        // flushed issue of r6 must never be seen
        a_set(1, 1, 0, 5'd6, 32'h66, 1, 0, 0, 0, 0, 0); a_tick();
        repeat (4) begin
            a_set(0, 0, 0, 0, 0, 0, 5'd6, 1, 0, 0, 0);
            chk("t4_hit", a_hit_a, 0); chk("t4_wb_we", a_wb_we, 0);
            a_tick();
        end

        // randomized traffic against the model
        repeat (400) begin
            a_set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 7) == 0),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), $urandom);
            a_tick();
        end
        repeat (4) begin a_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); a_tick(); end

        // deep chain: a load becomes forwardable only on reaching stage 3, so three stall cycles
        b_set(1, 1, 1, 5'd4, 32'h0, 0, 0, 0); b_tick();
        b_set(1, 1, 0, 5'd7, 32'h7, 5'd4, 1, 32'hBEEF);
        nst = 0;
        while (b_stall && nst < 20) begin nst++; b_tick(); end
        chk("b_stalls", nst, 3);
        chk("b_hit", b_hit_a, 1);
        chk("b_fwd", b_fwd_a, 32'hBEEF);
        chk("b_cnt", b_stall_cnt, 3);

        // continuous load-use on the 8-deep instance drives its counter into saturation
        b_set(1, 1, 1, 5'd4, 32'h0, 5'd4, 1, 32'h1);
        guard = 0; seen1k = 0;
        while (c_seen < 32'h10005 && guard < 90000) begin
            b_tick();
            guard++;
            if (c_seen == 1000 && !seen1k) begin
                seen1k = 1;
                chk("c_cnt_1k", c_stall_cnt, 1000);
            end
        end
        chk("c_sat_reached", (c_seen >= 32'h10005), 1);
        chk("c_cnt_sat", c_stall_cnt, 16'hFFFF);

        // asynchronous reset mid-cycle clears everything immediately
        @(negedge clock);
        a_set(0, 0, 0, 0, 0, 0, 5'd3, 1, 5'd4, 1, 32'h99);
        #1 resetn = 1'b0;
        #1;
        mq.delete();
        m_cnt = '0;
        a_eval();
        chk("rst_c_cnt", c_stall_cnt, 0);
        chk("rst_c_stall", c_stall, 0);
        chk("rst_b_wb_we", b_wb_we, 0);
        chk("rst_b_cnt", b_stall_cnt, 0);
        #1 resetn = 1'b1;
        b_set(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        repeat (60) begin
            a_set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 7) == 0),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
            a_tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
